// File: rtl/nonce_tx_queue_pkg.sv
// rtl/nonce_tx_queue_pkg.sv - shared widths and tx FSM encoding for the nonce transmit queue
package nonce_tx_queue_pkg;

    localparam int DEF_NONCE_BITS = 32;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_ADDR_BITS  = 3;
    localparam int DEF_DROP_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SEND = 2'd2
    } tx_state_e;

endpackage

// File: rtl/nonce_tx_queue_if.sv
// rtl/nonce_tx_queue_if.sv - producer/consumer signal bundle around the nonce transmit queue
interface nonce_tx_queue_if
    import nonce_tx_queue_pkg::*;
#(
    parameter int NONCE_BITS = DEF_NONCE_BITS,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int DROP_BITS  = DEF_DROP_BITS
);
    logic                  got_ticket;
    logic [NONCE_BITS-1:0] nonce_in;
    logic                  flush;
    logic                  tx_busy;
    logic                  tx_ready;
    logic [NONCE_BITS-1:0] word;
    logic                  new_nonce;
    logic [ADDR_BITS:0]    q_count;
    logic [DROP_BITS-1:0]  drop_count;

    modport master (
        output got_ticket, nonce_in, flush, tx_busy,
        input  tx_ready, word, new_nonce, q_count, drop_count
    );

    modport slave (
        input  got_ticket, nonce_in, flush, tx_busy,
        output tx_ready, word, new_nonce, q_count, drop_count
    );
endinterface

// File: rtl/nonce_tx_queue_fifo.sv
// rtl/nonce_tx_queue_fifo.sv - circular nonce buffer with push/pop/clear and acceptance flag
module nonce_fifo
    import nonce_tx_queue_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_BITS  = DEF_ADDR_BITS,
    parameter int NONCE_BITS = DEF_NONCE_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [NONCE_BITS-1:0] din,
    output logic [NONCE_BITS-1:0] dout,
    output logic [ADDR_BITS:0]    count,
    output logic                  accept
);
    localparam int CW = ADDR_BITS + 1;

    logic [NONCE_BITS-1:0] mem_q [DEPTH];
    logic [NONCE_BITS-1:0] mem_d [DEPTH];
    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = 1'b0;
        do_pop   = 1'b0;
        accept   = 1'b0;
        if (clear) begin
            // A push landing with the clear becomes the sole entry in slot 0.
            rd_ptr_d = '0;
            accept   = push;
            if (push) begin
                mem_d[0] = din;
                wr_ptr_d = ADDR_BITS'(1);
                count_d  = CW'(1);
            end else begin
                wr_ptr_d = '0;
                count_d  = '0;
            end
        end else begin
            do_pop  = pop && (count_q != '0);
            do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
            accept  = do_push;
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + ADDR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/nonce_tx_queue.sv
// rtl/nonce_tx_queue.sv - synchronises golden-nonce tickets, queues them and drives the serial tx handshake
module nonce_tx_queue
    import nonce_tx_queue_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int ADDR_BITS    = DEF_ADDR_BITS,
    parameter int NONCE_BITS   = DEF_NONCE_BITS,
    parameter int DROP_BITS    = DEF_DROP_BITS,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    nonce_tx_queue_if.slave  bus
);
    localparam int TW = $clog2(BUSY_TIMEOUT);

    tx_state_e             state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [NONCE_BITS-1:0] word_q, word_d;
    logic [DROP_BITS-1:0]  drop_q, drop_d;
    logic                  aborted_q, aborted_d;
    logic                  new_nonce_q, new_nonce_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  sync3_q, sync3_d;

    logic                  ticket_edge;
    logic                  launch;
    logic                  pop;
    logic                  accept;
    logic [NONCE_BITS-1:0] head;
    logic [ADDR_BITS:0]    count;

    assign ticket_edge = sync2_q & ~sync3_q;
    assign launch      = (state_q == ST_IDLE) && (count != '0) && !bus.tx_busy;
    // After a flush the in-flight slot no longer exists, so its completion must not pop.
    assign pop         = (state_q == ST_SEND) && !bus.tx_busy && !aborted_q && !bus.flush;

    nonce_fifo #(
        .DEPTH      (DEPTH),
        .ADDR_BITS  (ADDR_BITS),
        .NONCE_BITS (NONCE_BITS)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (ticket_edge),
        .pop    (pop),
        .clear  (bus.flush),
        .din    (bus.nonce_in),
        .dout   (head),
        .count  (count),
        .accept (accept)
    );

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        word_d      = word_q;
        aborted_d   = aborted_q;
        drop_d      = drop_q;
        new_nonce_d = ticket_edge;
        sync1_d     = bus.got_ticket;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    word_d  = head;
                    timer_d = '0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (bus.tx_busy) begin
                    state_d = ST_SEND;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_SEND: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.flush && (state_d != ST_IDLE)) begin
            aborted_d = 1'b1;
        end
        if (state_d == ST_IDLE) begin
            aborted_d = 1'b0;
        end

        if (ticket_edge && !accept && (drop_q != '1)) begin
            drop_d = drop_q + DROP_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            word_q      <= '0;
            aborted_q   <= 1'b0;
            drop_q      <= '0;
            new_nonce_q <= 1'b0;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            word_q      <= word_d;
            aborted_q   <= aborted_d;
            drop_q      <= drop_d;
            new_nonce_q <= new_nonce_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
        end
    end

    // The head is presented in the launch cycle itself so word is valid alongside tx_ready.
    assign bus.tx_ready   = launch;
    assign bus.word       = launch ? head : word_q;
    assign bus.new_nonce  = new_nonce_q;
    assign bus.q_count    = count;
    assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_nonce_tx_queue.sv
// tb/tb_nonce_tx_queue.sv - directed self-checking bench for nonce_tx_queue
module tb_nonce_tx_queue;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    nonce_tx_queue_if bus ();

    nonce_tx_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticket(input logic [31:0] v);
        bus.nonce_in   = v;
        bus.got_ticket = 1'b1;
        repeat (3) tick();
        bus.got_ticket = 1'b0;
    endtask

    task automatic wait_ready(output logic ok, output logic [31:0] w);
        ok = 1'b0;
        w  = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (bus.tx_ready) begin
                ok = 1'b1;
                w  = bus.word;
            end
        end
    endtask

    task automatic serve(input int hold, output logic ok, output logic [31:0] w);
        wait_ready(ok, w);
        if (ok) begin
            tick();
            bus.tx_busy = 1'b1;
            repeat (hold) tick();
            bus.tx_busy = 1'b0;
        end
    endtask

    task automatic drained(input string tag);
        @(negedge clk);
        @(negedge clk);
        check(tag, bus.q_count, 0);
    endtask

    initial begin
        logic        ok;
        logic [31:0] w;
        int          cnt;
        int          gap;

        rst            = 1'b1;
        bus.got_ticket = 1'b0;
        bus.nonce_in   = '0;
        bus.flush      = 1'b0;
        bus.tx_busy    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_ready", bus.tx_ready, 0);
        check("rst_q_count", bus.q_count, 0);
        check("rst_drop", bus.drop_count, 0);
        check("rst_word", bus.word, 0);
        check("rst_new_nonce", bus.new_nonce, 0);

        // 1: single ticket, latency and full handshake
        tick();
        bus.nonce_in   = 32'hDEADBEEF;
        bus.got_ticket = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_nn_early", bus.new_nonce, 0);
        @(negedge clk);
        check("t1_nn_at3", bus.new_nonce, 1);
        check("t1_q1", bus.q_count, 1);
        check("t1_ready", bus.tx_ready, 1);
        check("t1_word", bus.word, 32'hDEADBEEF);
        tick();
        bus.tx_busy    = 1'b1;
        bus.got_ticket = 1'b0;
        @(negedge clk);
        check("t1_nn_pulse", bus.new_nonce, 0);
        check("t1_ready_arm", bus.tx_ready, 0);
        check("t1_word_arm", bus.word, 32'hDEADBEEF);
        cnt = 0;
        repeat (99) begin
            @(negedge clk);
            if (bus.tx_ready) cnt++;
        end
        check("t1_no_extra_ready", cnt, 0);
        check("t1_q_busy", bus.q_count, 1);
        tick();
        bus.tx_busy = 1'b0;
        @(negedge clk);
        check("t1_q_before_pop", bus.q_count, 1);
        @(negedge clk);
        check("t1_q_after_pop", bus.q_count, 0);
        check("t1_ready_empty", bus.tx_ready, 0);

        // 2: overfill while busy, then ordered drain
        tick();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ticket(32'hA000_0000 + i);
            repeat (3) tick();
        end
        @(negedge clk);
        check("t2_q_full", bus.q_count, 8);
        check("t2_drop", bus.drop_count, 1);
        tick();
        bus.tx_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            serve(3, ok, w);
            check("t2_ready_seen", ok, 1);
            check("t2_word_order", w, 32'hA000_0000 + i);
        end
        drained("t2_q_drained");

        // 3: held-high ticket pushes once
        tick();
        bus.tx_busy    = 1'b1;
        bus.nonce_in   = 32'h1234_5678;
        bus.got_ticket = 1'b1;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.new_nonce) cnt++;
        end
        check("t3_one_new_nonce", cnt, 1);
        check("t3_one_push", bus.q_count, 1);
        tick();
        bus.got_ticket = 1'b0;
        repeat (3) tick();

        // 4: no busy response -> periodic resend of the same head
        bus.tx_busy = 1'b0;
        wait_ready(ok, w);
        check("t4_first_ready", ok, 1);
        check("t4_first_word", w, 32'h1234_5678);
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            for (int i = 1; i <= 40 && gap == 0; i++) begin
                @(negedge clk);
                if (bus.tx_ready) gap = i;
            end
            check("t4_resend_gap", gap, 17);
            check("t4_resend_word", bus.word, 32'h1234_5678);
            check("t4_q_held", bus.q_count, 1);
        end
        serve(2, ok, w);
        check("t4_final_word", w, 32'h1234_5678);
        drained("t4_q_drained");

        // 5: flush during SEND
        tick();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ticket(32'hB000_0000 + i);
            repeat (3) tick();
        end
        @(negedge clk);
        check("t5_q3", bus.q_count, 3);
        tick();
        bus.tx_busy = 1'b0;
        wait_ready(ok, w);
        check("t5_word", w, 32'hB000_0000);
        tick();
        bus.tx_busy = 1'b1;
        repeat (3) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        @(negedge clk);
        check("t5_q_flushed", bus.q_count, 0);
        check("t5_word_held", bus.word, 32'hB000_0000);
        repeat (4) tick();
        bus.tx_busy = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.tx_ready) cnt++;
        end
        check("t5_no_ready", cnt, 0);
        check("t5_q_after", bus.q_count, 0);
        check("t5_drop_kept", bus.drop_count, 1);

        // 6: reset in ARM with 4 entries queued
        tick();
        bus.tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ticket(32'hC000_0000 + i);
            repeat (3) tick();
        end
        @(negedge clk);
        check("t6_q4", bus.q_count, 4);
        tick();
        bus.tx_busy = 1'b0;
        wait_ready(ok, w);
        check("t6_ready", ok, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready_rst", bus.tx_ready, 0);
        check("t6_q_rst", bus.q_count, 0);
        check("t6_drop_rst", bus.drop_count, 0);
        check("t6_word_rst", bus.word, 0);
        tick();
        ticket(32'hD00D_F00D);
        serve(4, ok, w);
        check("t6_after_ready", ok, 1);
        check("t6_after_word", w, 32'hD00D_F00D);
        drained("t6_q_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
